// File: rtl/seq_right_shifter.sv
// Multi-cycle right shifter: captures an operand on start and shifts it one bit per clock.
// Logical, arithmetic and rotate modes; the result is held until the next completion.
module seq_right_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5   // 2**SHW must be >= WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shift_amount,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shifted_data
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [1:0] MODE_ARITH  = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] work_reg, work_next;
  logic [SHW-1:0]   cnt_reg, cnt_next;
  logic [1:0]       mode_reg, mode_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] result_reg, result_next;

  logic             fill_bit;
  logic [WIDTH-1:0] work_shr;

  // Bit shifted into the MSB; mode 11 falls through to logical.
  always_comb begin
    fill_bit = 1'b0;
    case (mode_reg)
      MODE_ARITH:  fill_bit = work_reg[WIDTH-1];
      MODE_ROTATE: fill_bit = work_reg[0];
      default:     fill_bit = 1'b0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shr
      assign work_shr[gi] = work_reg[gi+1];
    end
  endgenerate
  assign work_shr[WIDTH-1] = fill_bit;

  always_comb begin
    state_next  = state_reg;
    work_next   = work_reg;
    cnt_next    = cnt_reg;
    mode_next   = mode_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    result_next = result_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          work_next  = data_in;
          cnt_next   = shift_amount;
          mode_next  = mode;
          busy_next  = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_reg != '0) begin
          work_next = work_shr;
          cnt_next  = cnt_reg - SHW'(1);
        end else begin
          // Only this transition ever touches the visible result.
          result_next = work_reg;
          done_next   = 1'b1;
          busy_next   = 1'b0;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      work_reg   <= '0;
      cnt_reg    <= '0;
      mode_reg   <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      work_reg   <= work_next;
      cnt_reg    <= cnt_next;
      mode_reg   <= mode_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      result_reg <= result_next;
    end
  end

  assign busy         = busy_reg;
  assign done         = done_reg;
  assign shifted_data = result_reg;

endmodule

// File: doc/seq_right_shifter.md
Name: seq_right_shifter

Overview:
- Multi-cycle right shifter; the companion to the team's combinational left shifter.
- Accepts one operand on a start strobe and shifts it right one bit per clock.
- Supports logical, arithmetic and rotate modes.
- Reports busy/done and holds the result until the next operation.
- Sits next to the combinational shifter in the datapath, for area-constrained users that can tolerate latency.

Parameters:
- WIDTH, 32, data width in bits.
- SHW, 5, width of shift_amount; must satisfy 2**SHW >= WIDTH.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request strobe; sampled only when idle.
- data_in  input  WIDTH  operand, captured at the accept edge.
- shift_amount  input  SHW  number of bit positions to shift right, captured at the accept edge.
- mode  input  2  00 logical right, 01 arithmetic right, 10 rotate right, 11 treated as logical; captured at the accept edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when shifted_data is updated.
- shifted_data  output  WIDTH  registered result; holds its value until the next done.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; busy=0, done=0, shifted_data=0.
  - Internal work register and counter cleared.
  - Takes priority over all other inputs, including mid-operation; an aborted operation never produces done.
- States: IDLE, SHIFT.
- IDLE:
  - done defaults to 0 unless set by the completing transition.
  - If start=1 at an edge (the accept edge): work<=data_in, cnt<=shift_amount, mode_r<=mode, busy<=1, state<=SHIFT.
  - start=0: remain in IDLE.
- SHIFT, cnt!=0: work shifts right by exactly one bit and cnt<=cnt-1. The vacated MSB is:
  - 0 in logical mode;
  - work[WIDTH-1] in arithmetic mode;
  - work[0] in rotate mode.
- SHIFT, cnt==0: shifted_data<=work, done<=1, busy<=0, state<=IDLE.
- Latency: done is high in the cycle beginning shift_amount+1 edges after the accept edge.
  - shift_amount=0 gives a 1-cycle latency, with result = data_in.
- Throughput: a new start is accepted in the same cycle done is high (state is IDLE). Back-to-back operations therefore have no dead cycle beyond done.
- start while busy=1 is ignored: no queueing, and captured operands are unaffected.
- data_in, shift_amount and mode may change freely after the accept edge without affecting the operation.
- shifted_data changes only on the edge that raises done (or on reset). Intermediate shift values are never visible on shifted_data.
- shift_amount >= WIDTH (possible when 2**SHW > WIDTH) is not an error. The block shifts the full count:
  - logical result is 0;
  - arithmetic result is all copies of the sign bit;
  - rotate result is a rotate by (amount mod WIDTH).
- done is exactly one cycle wide. busy and done are never high together.

Test Plan:
- Reset, then start with data_in=32'hB000_0000, shift_amount=4, mode=00 -> busy=1 for 5 cycles; done pulses 5 edges after accept; shifted_data=32'h0B00_0000.
- Arithmetic: data_in=32'h8000_0000, shift_amount=3, mode=01 -> shifted_data=32'hF000_0000. Repeat with 32'h4000_0000 -> 32'h0800_0000.
- Rotate: data_in=32'h0000_000B, shift_amount=1, mode=10 -> 32'h8000_0005. data_in=32'h0000_0001, shift_amount=31, mode=10 -> 32'h0000_0002 after 32 cycles.
- Zero shift: data_in=32'hDEAD_BEEF, shift_amount=0, mode=00 -> done one edge after accept; shifted_data=32'hDEAD_BEEF.
- Busy protection: start amount=7 on 32'h0000_00FF logical, then re-pulse start with different operands at cycles 2-5 -> a single done at cycle 8, result 32'h0000_0001. Next start issued in the done cycle is accepted.
- Reset mid-operation: start amount=10, assert rst_n=0 at cycle 4 -> busy, done and shifted_data are 0 the next cycle; no done pulse follows. A fresh operation then completes normally.
